// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache. It sits between the
// MEM pipeline stage and a slow line-based main memory.
//   - A hit completes in the same cycle with no stall.
//   - A miss raises cpu_stall_o, writes back a dirty victim if there is one,
//     refills the line, and then completes the access as an ordinary hit.
//
// Ports
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   cpu_req_i        : MEM-stage access valid
//   cpu_we_i         : 1 = store, 0 = load
//   cpu_addr_i       : byte address; [3:2] word, [3+IDX_W:4] index, rest tag
//   cpu_wdata_i      : store data
//   cpu_rdata_o      : load data; valid on an unstalled load, otherwise 0
//   cpu_stall_o      : freezes the front of the pipeline
//   mem_req_o        : memory request level
//   mem_we_o         : 1 = line writeback, 0 = line refill
//   mem_addr_o       : line-aligned memory address
//   mem_wdata_o      : victim line (word 0 in [31:0])
//   mem_rdata_i      : refill line, sampled while mem_ack_i = 1
//   mem_ack_i        : one-cycle pulse that ends the current transaction
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_wdata_o,
    input  logic [127:0] mem_rdata_i,
    input  logic         mem_ack_i
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Per-line storage. Only the valid and dirty bits are reset.
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    // Memory-side transaction registers. These are held for the whole
    // transaction.
    logic         mem_we_q,    mem_we_d;
    logic [31:0]  mem_addr_q,  mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    // Decoded CPU address.
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [1:0]       off_s;
    logic             unused_addr_s;

    logic         hit_s;
    logic [127:0] line_s;
    logic [31:0]  word_s;
    logic         store_hit_s;
    logic         fill_s;

    // Builds a line-aligned memory address from a tag and an index.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, 4'b0000};
    endfunction

    assign idx_s         = cpu_addr_i[3+IDX_W:4];
    assign tag_s         = cpu_addr_i[31:4+IDX_W];
    assign off_s         = cpu_addr_i[3:2];
    assign unused_addr_s = ^cpu_addr_i[1:0];

    assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign line_s = data_q[idx_s];
    assign word_s = line_s[{off_s, 5'b00000} +: 32];

    // mem_req_o follows the state register. Because the state register is
    // reset asynchronously, the request drops as soon as reset is asserted.
    assign mem_req_o   = (state_q != ST_IDLE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // CPU-facing outputs: the stall is combinational on a miss, and the load
    // data is combinational on a hit. Reset forces both outputs to 0 even
    // while a request is still presented.
    always_comb begin
        cpu_stall_o = 1'b0;
        cpu_rdata_o = 32'h0000_0000;
        if (rst_i) begin
            cpu_stall_o = 1'b0;
        end else if (state_q != ST_IDLE) begin
            cpu_stall_o = 1'b1;
        end else if (cpu_req_i && !hit_s) begin
            cpu_stall_o = 1'b1;
        end else if (cpu_req_i && !cpu_we_i) begin
            cpu_rdata_o = word_s;
        end else begin
            cpu_rdata_o = 32'h0000_0000;
        end
    end

    // Next-state logic, memory transaction setup, and line update strobes.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        store_hit_s = 1'b0;
        fill_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cpu_req_i) begin
                    state_d = ST_IDLE;
                end else if (hit_s) begin
                    store_hit_s = cpu_we_i;
                end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
                    // A dirty victim goes out first. The refill address is
                    // loaded when the writeback is acknowledged.
                    state_d     = ST_WRITEBACK;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = line_addr(tag_q[idx_s], idx_s);
                    mem_wdata_d = line_s;
                end else begin
                    state_d    = ST_ALLOCATE;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr(tag_s, idx_s);
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d    = ST_ALLOCATE;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr(tag_s, idx_s);
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    // The CPU inputs are held during a stall, so the index and
                    // tag still describe the line being refilled.
                    fill_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, valid/dirty bits, and memory transaction registers (async reset).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= {NUM_SETS{1'b0}};
            dirty_q     <= {NUM_SETS{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 128'h0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (fill_s) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end else if (store_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays. These are not reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (fill_s) begin
            tag_q[idx_s]  <= tag_s;
            data_q[idx_s] <= mem_rdata_i;
        end else if (store_hit_s) begin
            data_q[idx_s][{off_s, 5'b00000} +: 32] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
//
// Directed testbench for dcache_controller.
//   - Expected load data and expected memory transactions are queued when an
//     access is issued, then popped and compared when the cache completes the
//     access or acknowledges a transaction.
//   - The memory model returns a fixed pattern for any line that has never
//     been written back, and returns the stored data for lines that have.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
    } tx_t;

    tx_t          tx_q[$];
    logic [31:0]  rd_q[$];
    logic [127:0] mem_m [logic [31:0]];

    int checks = 0;
    int errors = 0;

    dcache_controller #(.NUM_SETS(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    function automatic logic [127:0] pat_line(input logic [31:0] b);
        return {pat(b + 32'd12), pat(b + 32'd8), pat(b + 32'd4), pat(b)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic we, input logic [31:0] addr, input logic [127:0] data);
        tx_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        tx_q.push_back(t);
    endtask

    // Performs one CPU access. The memory acknowledges each transaction in its
    // lat-th request cycle. The task checks the stall length and the load data.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input int exp_stall,
                          input logic [31:0] exp_rd);
        int   cyc;
        int   stalls;
        int   reqcnt;
        tx_t  t;
        logic [31:0] rd;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        if (!we) rd_q.push_back(exp_rd);
        #1;
        cyc    = 0;
        stalls = 0;
        reqcnt = 0;
        while (cpu_stall_o === 1'b1 && cyc < 100) begin
            stalls++;
            check({tag, ".req"}, mem_req_o, (cyc != 0));
            check({tag, ".rdata_stall"}, cpu_rdata_o, 32'h0);
            if (mem_req_o) begin
                reqcnt++;
                if (reqcnt == lat) begin
                    check({tag, ".tx_pending"}, (tx_q.size() > 0), 1'b1);
                    if (tx_q.size() > 0) begin
                        t = tx_q.pop_front();
                        check({tag, ".mem_we"}, mem_we_o, t.we);
                        check({tag, ".mem_addr"}, mem_addr_o, t.addr);
                        if (t.we) check({tag, ".mem_wdata"}, mem_wdata_o, t.data);
                    end
                    if (mem_we_o) mem_m[mem_addr_o] = mem_wdata_o;
                    else mem_rdata_i = mem_m.exists(mem_addr_o) ? mem_m[mem_addr_o]
                                                                : pat_line(mem_addr_o);
                    mem_ack_i = 1'b1;
                    reqcnt    = 0;
                end
            end
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            cyc++;
        end
        check({tag, ".no_timeout"}, (cyc < 100), 1'b1);
        check({tag, ".stall_cycles"}, stalls, exp_stall);
        if (!we) begin
            rd = rd_q.pop_front();
            check({tag, ".rdata"}, cpu_rdata_o, rd);
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h0000_0104;
        cpu_wdata_i = 32'h0;
        mem_rdata_i = 128'h0;
        mem_ack_i   = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.stall", cpu_stall_o, 1'b0);
        check("rst.rdata", cpu_rdata_o, 32'h0);
        check("rst.req", mem_req_o, 1'b0);
        check("rst.we", mem_we_o, 1'b0);
        check("rst.addr", mem_addr_o, 32'h0);
        check("rst.wdata", mem_wdata_o, 128'h0);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Cold load, with the ack in the 3rd request cycle.
        push_tx(1'b0, 32'h0000_0100, 128'h0);
        access("cold_ld", 1'b0, 32'h0000_0104, 32'h0, 3, 4, pat(32'h0000_0104));

        // A store hit, then a load hit in the next cycle.
        access("st_hit", 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1, 0, 32'h0);
        access("ld_hit", 1'b0, 32'h0000_0104, 32'h0, 1, 0, 32'hDEAD_BEEF);

        // A dirty conflict miss: writeback of 0x100, then refill of 0x1100.
        push_tx(1'b1, 32'h0000_0100, {pat(32'h10C), pat(32'h108), 32'hDEAD_BEEF, pat(32'h100)});
        push_tx(1'b0, 32'h0000_1100, 128'h0);
        access("dirty_miss", 1'b0, 32'h0000_1104, 32'h0, 2, 5, pat(32'h0000_1104));

        // A clean miss back to 0x104 returns the written-back store data.
        push_tx(1'b0, 32'h0000_0100, 128'h0);
        access("reload", 1'b0, 32'h0000_0104, 32'h0, 1, 2, 32'hDEAD_BEEF);

        // A store miss: refill, then the store word is merged into the line.
        push_tx(1'b0, 32'h0000_0200, 128'h0);
        access("st_miss", 1'b1, 32'h0000_0208, 32'h1234_5678, 2, 3, 32'h0);
        access("ld_merged", 1'b0, 32'h0000_0208, 32'h0, 1, 0, 32'h1234_5678);
        access("ld_neigh", 1'b0, 32'h0000_020C, 32'h0, 1, 0, pat(32'h0000_020C));

        // A conflicting miss with 1-cycle acks writes back the merged line.
        push_tx(1'b1, 32'h0000_0200, {pat(32'h20C), 32'h1234_5678, pat(32'h204), pat(32'h200)});
        push_tx(1'b0, 32'h0000_1200, 128'h0);
        access("b2b_miss", 1'b0, 32'h0000_1208, 32'h0, 1, 3, pat(32'h0000_1208));

        // A spurious ack while IDLE must have no effect.
        mem_ack_i   = 1'b1;
        mem_rdata_i = {4{32'hFFFF_FFFF}};
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
        check("spurious.req", mem_req_o, 1'b0);
        check("spurious.stall", cpu_stall_o, 1'b0);
        access("after_spur", 1'b0, 32'h0000_1208, 32'h0, 1, 0, pat(32'h0000_1208));

        // Reset asserted during ALLOCATE, before any ack arrives.
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0300;
        #1;
        check("rstmid.miss_stall", cpu_stall_o, 1'b1);
        check("rstmid.req0", mem_req_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("rstmid.req1", mem_req_o, 1'b1);
        check("rstmid.we", mem_we_o, 1'b0);
        check("rstmid.addr", mem_addr_o, 32'h0000_0300);
        rst_i = 1'b1;
        #1;
        check("rstmid.req_drop", mem_req_o, 1'b0);
        check("rstmid.stall_drop", cpu_stall_o, 1'b0);
        check("rstmid.rdata", cpu_rdata_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;

        // All lines are invalid after reset, so both of these accesses miss again.
        push_tx(1'b0, 32'h0000_1200, 128'h0);
        access("post_rst_a", 1'b0, 32'h0000_1208, 32'h0, 1, 2, pat(32'h0000_1208));
        push_tx(1'b0, 32'h0000_0300, 128'h0);
        access("post_rst_b", 1'b0, 32'h0000_0300, 32'h0, 1, 2, pat(32'h0000_0300));

        check("tx_queue_drained", tx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
